// File: rtl/paddle_ctrl.sv
// paddle_ctrl: two-player paddle position controller with game-phase FSM.
// Turns per-player left/right step pulses into saturating paddle positions,
// rate-limits each player with a cooldown, and sequences IDLE -> PLAY ->
// RECENTER -> SERVE -> PLAY around scored points.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    level, leaves IDLE
//   point                    pulse from ball logic, honoured in PLAY only
//   p1/p2_left_op/right_op   per-player step pulses
//   p1_pos, p2_pos           registered paddle positions
//   p1_moved, p2_moved       one-cycle pulse per accepted step
//   serve                    one-cycle pulse on the first PLAY cycle after SERVE
//   state                    IDLE=0, PLAY=1, RECENTER=2, SERVE=3
module paddle_ctrl #(
    parameter int unsigned POS_W    = 4,
    parameter int unsigned POS_MAX  = 12,
    parameter int unsigned POS_INIT = 6,
    parameter int unsigned COOLDOWN = 3,
    parameter int unsigned HOLD_CYC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             point,
    input  logic             p1_left_op,
    input  logic             p1_right_op,
    input  logic             p2_left_op,
    input  logic             p2_right_op,
    output logic [POS_W-1:0] p1_pos,
    output logic [POS_W-1:0] p2_pos,
    output logic             p1_moved,
    output logic             p2_moved,
    output logic             serve,
    output logic [1:0]       state
);

    localparam int unsigned CD_W   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_PLAY     = 2'd1;
    localparam logic [1:0] S_RECENTER = 2'd2;
    localparam logic [1:0] S_SERVE    = 2'd3;

    localparam logic [POS_W-1:0]  W_MAX  = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]  W_INIT = POS_W'(POS_INIT);
    localparam logic [CD_W-1:0]   W_CD   = CD_W'(COOLDOWN);
    localparam logic [HOLD_W-1:0] W_HOLD = HOLD_W'(HOLD_CYC - 1);

    logic [1:0]        r_state,  w_state_n;
    logic [POS_W-1:0]  r_p1_pos, w_p1_pos_n;
    logic [POS_W-1:0]  r_p2_pos, w_p2_pos_n;
    logic [CD_W-1:0]   r_cd1,    w_cd1_n;
    logic [CD_W-1:0]   r_cd2,    w_cd2_n;
    logic [HOLD_W-1:0] r_hold,   w_hold_n;
    logic              r_p1_moved, w_p1_moved_n;
    logic              r_p2_moved, w_p2_moved_n;
    logic              r_serve,    w_serve_n;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_p1_pos   <= W_INIT;
            r_p2_pos   <= W_INIT;
            r_cd1      <= '0;
            r_cd2      <= '0;
            r_hold     <= '0;
            r_p1_moved <= 1'b0;
            r_p2_moved <= 1'b0;
            r_serve    <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_p1_pos   <= w_p1_pos_n;
            r_p2_pos   <= w_p2_pos_n;
            r_cd1      <= w_cd1_n;
            r_cd2      <= w_cd2_n;
            r_hold     <= w_hold_n;
            r_p1_moved <= w_p1_moved_n;
            r_p2_moved <= w_p2_moved_n;
            r_serve    <= w_serve_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_n    = r_state;
        w_p1_pos_n   = r_p1_pos;
        w_p2_pos_n   = r_p2_pos;
        w_cd1_n      = r_cd1;
        w_cd2_n      = r_cd2;
        w_hold_n     = r_hold;
        w_p1_moved_n = 1'b0;
        w_p2_moved_n = 1'b0;
        w_serve_n    = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) w_state_n = S_PLAY;
            end

            S_PLAY: begin
                if (point) begin
                    // Point beats any same-cycle step; cooldowns restart clean.
                    w_cd1_n   = '0;
                    w_cd2_n   = '0;
                    w_state_n = S_RECENTER;
                end else begin
                    // Player 1: cooldown, conflict, then bounded step.
                    if (r_cd1 != '0) begin
                        w_cd1_n = r_cd1 - CD_W'(1);
                    end else if (p1_left_op && p1_right_op) begin
                        w_cd1_n = r_cd1;
                    end else if (p1_left_op && (r_p1_pos != '0)) begin
                        w_p1_pos_n   = r_p1_pos - POS_W'(1);
                        w_p1_moved_n = 1'b1;
                        w_cd1_n      = W_CD;
                    end else if (p1_right_op && (r_p1_pos < W_MAX)) begin
                        w_p1_pos_n   = r_p1_pos + POS_W'(1);
                        w_p1_moved_n = 1'b1;
                        w_cd1_n      = W_CD;
                    end
                    // Player 2: same rules, independent state.
                    if (r_cd2 != '0) begin
                        w_cd2_n = r_cd2 - CD_W'(1);
                    end else if (p2_left_op && p2_right_op) begin
                        w_cd2_n = r_cd2;
                    end else if (p2_left_op && (r_p2_pos != '0)) begin
                        w_p2_pos_n   = r_p2_pos - POS_W'(1);
                        w_p2_moved_n = 1'b1;
                        w_cd2_n      = W_CD;
                    end else if (p2_right_op && (r_p2_pos < W_MAX)) begin
                        w_p2_pos_n   = r_p2_pos + POS_W'(1);
                        w_p2_moved_n = 1'b1;
                        w_cd2_n      = W_CD;
                    end
                end
            end

            S_RECENTER: begin
                // Equality is judged on current positions, costing one extra cycle.
                if ((r_p1_pos == W_INIT) && (r_p2_pos == W_INIT)) begin
                    w_state_n = S_SERVE;
                    w_hold_n  = W_HOLD;
                end else begin
                    if (r_p1_pos > W_INIT)      w_p1_pos_n = r_p1_pos - POS_W'(1);
                    else if (r_p1_pos < W_INIT) w_p1_pos_n = r_p1_pos + POS_W'(1);
                    if (r_p2_pos > W_INIT)      w_p2_pos_n = r_p2_pos - POS_W'(1);
                    else if (r_p2_pos < W_INIT) w_p2_pos_n = r_p2_pos + POS_W'(1);
                end
            end

            S_SERVE: begin
                if (r_hold == '0) begin
                    w_state_n = S_PLAY;
                    w_serve_n = 1'b1;
                end else begin
                    w_hold_n = r_hold - HOLD_W'(1);
                end
            end

            default: w_state_n = S_IDLE;
        endcase
    end

    assign p1_pos   = r_p1_pos;
    assign p2_pos   = r_p2_pos;
    assign p1_moved = r_p1_moved;
    assign p2_moved = r_p2_moved;
    assign serve    = r_serve;
    assign state    = r_state;

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: table-driven vectors plus hand-written multi-cycle sequences
// for paddle_ctrl; expected outputs are queued when inputs are driven and
// popped when the outputs are sampled after the clock edge.
module tb_paddle_ctrl;

    typedef struct packed {
        logic rst;
        logic start;
        logic point;
        logic l1;
        logic r1;
        logic l2;
        logic r2;
    } in_t;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       m1;
        logic       m2;
        logic       sv;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic       clk;
    logic       rst, start, point;
    logic       p1_left_op, p1_right_op, p2_left_op, p2_right_op;
    logic [3:0] p1_pos, p2_pos;
    logic       p1_moved, p2_moved, serve;
    logic [1:0] state;

    int   n_chk;
    int   n_pass;
    int   n_moved2;
    out_t exp_q[$];
    vec_t tbl[20];

    paddle_ctrl #(
        .POS_W(4), .POS_MAX(12), .POS_INIT(6), .COOLDOWN(3), .HOLD_CYC(8)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .point(point),
        .p1_left_op(p1_left_op), .p1_right_op(p1_right_op),
        .p2_left_op(p2_left_op), .p2_right_op(p2_right_op),
        .p1_pos(p1_pos), .p2_pos(p2_pos),
        .p1_moved(p1_moved), .p2_moved(p2_moved),
        .serve(serve), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic in_t mi(logic r, logic s, logic p, logic a, logic b, logic c, logic d);
        in_t v;
        v = '{rst: r, start: s, point: p, l1: a, r1: b, l2: c, r2: d};
        return v;
    endfunction

    function automatic out_t mo(logic [1:0] st, int a, int b, logic m1, logic m2, logic sv);
        out_t v;
        v = '{st: st, p1: 4'(a), p2: 4'(b), m1: m1, m2: m2, sv: sv};
        return v;
    endfunction

    // Drive one cycle of inputs, queue the expectation, compare after the edge.
    task automatic run(input in_t i, input out_t e, input string nm);
        out_t got, want;
        rst = i.rst; start = i.start; point = i.point;
        p1_left_op = i.l1; p1_right_op = i.r1;
        p2_left_op = i.l2; p2_right_op = i.r2;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got  = '{st: state, p1: p1_pos, p2: p2_pos, m1: p1_moved, m2: p2_moved, sv: serve};
        want = exp_q.pop_front();
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got st=%0d p1=%0d p2=%0d m1=%0b m2=%0b sv=%0b, want st=%0d p1=%0d p2=%0d m1=%0b m2=%0b sv=%0b",
                      nm, got.st, got.p1, got.p2, got.m1, got.m2, got.sv,
                      want.st, want.p1, want.p2, want.m1, want.m2, want.sv);
    endtask

    function automatic in_t rnd_in();
        in_t v;
        v = in_t'({1'b0, 6'($urandom)});
        return v;
    endfunction

    initial begin
        int p1e, p2e;
        in_t zero;
        n_chk = 0; n_pass = 0; n_moved2 = 0;
        zero = mi(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1; start = 1'b0; point = 1'b0;
        p1_left_op = 1'b0; p1_right_op = 1'b0; p2_left_op = 1'b0; p2_right_op = 1'b0;

        // Reset, ignored inputs in IDLE, start, cooldown spacing, conflict.
        tbl[0]  = '{mi(1, 0, 0, 0, 0, 0, 0), mo(0, 6, 6, 0, 0, 0)};
        tbl[1]  = '{mi(1, 1, 1, 1, 0, 0, 1), mo(0, 6, 6, 0, 0, 0)};
        tbl[2]  = '{mi(0, 0, 1, 1, 0, 0, 1), mo(0, 6, 6, 0, 0, 0)};
        tbl[3]  = '{mi(0, 1, 0, 0, 0, 0, 0), mo(1, 6, 6, 0, 0, 0)};
        tbl[4]  = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 6, 6, 0, 0, 0)};
        tbl[5]  = '{mi(0, 0, 0, 0, 1, 0, 0), mo(1, 7, 6, 1, 0, 0)};
        tbl[6]  = '{mi(0, 0, 0, 0, 1, 0, 0), mo(1, 7, 6, 0, 0, 0)};
        tbl[7]  = '{mi(0, 0, 0, 0, 1, 0, 0), mo(1, 7, 6, 0, 0, 0)};
        tbl[8]  = '{mi(0, 0, 0, 0, 1, 0, 0), mo(1, 7, 6, 0, 0, 0)};
        tbl[9]  = '{mi(0, 0, 0, 0, 1, 0, 0), mo(1, 8, 6, 1, 0, 0)};
        tbl[10] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 8, 6, 0, 0, 0)};
        tbl[11] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 8, 6, 0, 0, 0)};
        tbl[12] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 8, 6, 0, 0, 0)};
        tbl[13] = '{mi(0, 0, 0, 1, 1, 0, 0), mo(1, 8, 6, 0, 0, 0)};
        tbl[14] = '{mi(0, 0, 0, 1, 0, 0, 0), mo(1, 7, 6, 1, 0, 0)};
        tbl[15] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 7, 6, 0, 0, 0)};
        tbl[16] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 7, 6, 0, 0, 0)};
        tbl[17] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 7, 6, 0, 0, 0)};
        tbl[18] = '{mi(0, 0, 0, 0, 1, 1, 1), mo(1, 8, 6, 1, 0, 0)};
        tbl[19] = '{mi(0, 0, 0, 0, 0, 0, 0), mo(1, 8, 6, 0, 0, 0)};
        for (int k = 0; k < 20; k++) run(tbl[k].i, tbl[k].o, $sformatf("vec%0d", k));
        run(zero, mo(1, 8, 6, 0, 0, 0), "cd_drain_a");
        run(zero, mo(1, 8, 6, 0, 0, 0), "cd_drain_b");

        // Player 2 walks left to the lower bound; only real moves pulse.
        p2e = 6;
        for (int t = 0; t < 10; t++) begin
            logic mv;
            mv  = (p2e > 0);
            p2e = mv ? p2e - 1 : 0;
            run(mi(0, 0, 0, 0, 0, 1, 0), mo(1, 8, p2e, 0, mv, 0), $sformatf("sat_try%0d", t));
            if (p2_moved === 1'b1) n_moved2++;
            for (int w = 0; w < 3; w++) run(zero, mo(1, 8, p2e, 0, 0, 0), $sformatf("sat_wait%0d_%0d", t, w));
        end
        n_chk++;
        if (n_moved2 == 6) n_pass++;
        else $display("FAIL sat_pulse_count: got %0d want 6", n_moved2);

        // Player 1 up to 10.
        for (int t = 0; t < 2; t++) begin
            run(mi(0, 0, 0, 0, 1, 0, 0), mo(1, 9 + t, 0, 1, 0, 0), $sformatf("p1_up%0d", t));
            for (int w = 0; w < 3; w++) run(zero, mo(1, 9 + t, 0, 0, 0, 0), $sformatf("p1_up_wait%0d_%0d", t, w));
        end

        // Point with a simultaneous step: step dropped, 7-cycle recenter, 8-cycle serve.
        run(mi(0, 0, 1, 1, 0, 0, 0), mo(2, 10, 0, 0, 0, 0), "point_step");
        for (int k = 1; k <= 6; k++) begin
            p1e = (10 - k < 6) ? 6 : 10 - k;
            p2e = (k > 6) ? 6 : k;
            run(rnd_in(), mo(2, p1e, p2e, 0, 0, 0), $sformatf("recenter%0d", k));
        end
        run(rnd_in(), mo(3, 6, 6, 0, 0, 0), "serve_enter");
        for (int k = 1; k < 8; k++) run(rnd_in(), mo(3, 6, 6, 0, 0, 0), $sformatf("serve%0d", k));
        run(zero, mo(1, 6, 6, 0, 0, 0) | out_t'(13'd1), "serve_pulse");
        run(zero, mo(1, 6, 6, 0, 0, 0), "serve_once");

        // Reset during the third SERVE cycle.
        run(mi(0, 0, 0, 1, 0, 0, 0), mo(1, 5, 6, 1, 0, 0), "pre_step");
        run(mi(0, 0, 1, 0, 0, 0, 0), mo(2, 5, 6, 0, 0, 0), "point2");
        run(zero, mo(2, 6, 6, 0, 0, 0), "recenter2");
        run(zero, mo(3, 6, 6, 0, 0, 0), "serve2_1");
        run(zero, mo(3, 6, 6, 0, 0, 0), "serve2_2");
        run(mi(1, 0, 0, 0, 0, 0, 0), mo(0, 6, 6, 0, 0, 0), "rst_mid_serve");
        run(mi(0, 0, 1, 1, 0, 0, 1), mo(0, 6, 6, 0, 0, 0), "idle_after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
# paddle_ctrl

Two-player paddle controller for the pong datapath. It takes the one-cycle `left_op`/`right_op` step pulses from each player's sensor direction decoder and turns them into saturating paddle positions. Steps are rate-limited per player by a cooldown. A game-phase state machine freezes paddles before start, recenters them after each point, and holds a serve delay before play resumes. It sits between the two direction decoders and the ball/render logic, which read `p1_pos`/`p2_pos` and use `serve` to launch the ball.

## Interface
- `POS_W`, 4, width of the position outputs.
- `POS_MAX`, 12, highest legal paddle position. Constraint: `POS_INIT <= POS_MAX < 2**POS_W`.
- `POS_INIT`, 6, reset and recenter position.
- `COOLDOWN`, 3, cycles a player's steps are ignored after an accepted move; 0 disables the cooldown.
- `HOLD_CYC`, 8, length of the SERVE phase in cycles, at least 1.
- `clk`  in  1  sole clock; every register updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  level, sampled in IDLE only.
- `point`  in  1  one-cycle pulse from ball logic; sampled in PLAY only.
- `p1_left_op`, `p1_right_op`  in  1  player 1 step pulses.
- `p2_left_op`, `p2_right_op`  in  1  player 2 step pulses.
- `p1_pos`, `p2_pos`  out  POS_W  registered paddle positions.
- `p1_moved`, `p2_moved`  out  1  one-cycle pulse when a player step is accepted.
- `serve`  out  1  one-cycle pulse on SERVE→PLAY.
- `state`  out  2  IDLE=0, PLAY=1, RECENTER=2, SERVE=3.

## Operation
- **Reset.** While `rst`=1 at an edge:
  - `state`=IDLE and `p1_pos`=`p2_pos`=POS_INIT.
  - `p1_moved`=`p2_moved`=`serve`=0.
  - Cooldown counters and the hold counter are 0.
  - `rst` overrides every other input in any state, including mid-recenter and mid-serve.
- **IDLE.** All step and `point` inputs are ignored. `start`=1 moves to PLAY at the next edge. No `serve` pulse is issued for this transition.
- **PLAY, per player, independently:**
  - If the player's cooldown is nonzero, decrement it and ignore that player's steps this cycle.
  - Else if left=1 and right=1 together, ignore both.
  - Else if left=1 and pos>0: pos decrements, moved pulses, cooldown loads COOLDOWN.
  - Else if right=1 and pos<POS_MAX: pos increments, moved pulses, cooldown loads COOLDOWN.
  - A step at a bound (left at pos 0, right at POS_MAX) is ignored: no pulse, no cooldown load.
- **PLAY, point.** `point`=1 has priority over both players' steps in the same cycle. Those steps are dropped, both cooldowns clear, and the next state is RECENTER.
- **RECENTER.**
  - Each cycle, each paddle moves one step toward POS_INIT; a paddle already at POS_INIT stays.
  - No `moved` pulses are issued, and steps and `point` are ignored.
  - When both positions equal POS_INIT at the sampling edge, the next state is SERVE and the hold counter loads HOLD_CYC-1.
- **SERVE.**
  - Steps, `point` and `start` are ignored.
  - The hold counter decrements each cycle.
  - When the counter is 0 at an edge, the next state is PLAY and `serve`=1 for exactly that one PLAY cycle.
- **Widths.** Position arithmetic stays within POS_W with no wrap; saturation guarantees 0..POS_MAX. The cooldown counter is wide enough for COOLDOWN; the hold counter is wide enough for HOLD_CYC.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **Step latency.** A step sampled at edge k that is accepted updates `pX_pos` and asserts `pX_moved` in the cycle after edge k. `pX_moved` deasserts after one cycle.
- **Step spacing.** After an accepted move at edge k, steps at edges k+1..k+COOLDOWN are ignored. The earliest next accepted step is at edge k+COOLDOWN+1.
- **Recenter length.** RECENTER lasts max(|p1_pos-POS_INIT|, |p2_pos-POS_INIT|)+1 cycles. The +1 is the cycle in which equality is detected. A point scored with both paddles already centered spends exactly 1 cycle in RECENTER.
- **Serve length.** SERVE lasts exactly HOLD_CYC cycles.
- `point` arriving on the same edge as an accepted step: the step is lost and the position is unchanged.

## Test plan
- **Reset and start.** Apply reset, then `start`=1 for 1 cycle -> `state` goes 0→1; positions 6/6; `serve` stays 0.
- **Cooldown.** In PLAY, `p1_right_op` pulsed at edges 0,1,2,3,4 -> `p1_pos` 6→7 after edge 0, 7→8 after edge 4; exactly two `p1_moved` pulses; `p2_pos` stays 6.
- **Saturation and conflict.**
  - Drive `p2_left_op` every 4th cycle for 10 accepted tries -> `p2_pos` settles at 0; pulses only for 6 real moves.
  - `p1_left_op`=`p1_right_op`=1 together -> no change and no pulse.
- **Point with simultaneous step.** With `p1_pos`=10 and `p2_pos`=0, `point` and `p1_left_op` together -> step dropped; RECENTER lasts 7 cycles to 6/6; SERVE lasts 8 cycles; one `serve` pulse coincides with the first PLAY cycle.
- **Inputs ignored outside PLAY.** Steps and `point` in IDLE, RECENTER and SERVE -> no position change beyond recenter motion; no `moved` pulses; the SERVE length is unchanged.
- **Reset mid-sequence.** Assert `rst` during the 3rd SERVE cycle -> next cycle `state`=0, positions 6/6, no `serve` pulse.
